cp0_unit: RTL and testbench
===========================

// Module: cp0_unit
// PURPOSE
//  Coprocessor-0 for the 5-stage MIPS core; sits beside the M stage of the datapath and consumes PC_M, the
//  M-stage store data (F5out) and the ALU address path. Holds SR/Cause/EPC/PRId, arbitrates hardware interrupts
//  against M-stage internal exceptions, and produces Exception, EPC and the mfc0 read value c0out for pipeWR.
//  Registers update on the clock edge that retires the M-stage instruction.
// PARAMETERS
//  PRID      32'h2017_0001  read-only value of CP0 reg 15
//  HWINT_W   6              number of hardware interrupt lines (maps to IP/IM bits [15:10])
//  EPC_RST   32'h0000_0000  reset value of EPC
// PORTS
//  clk        in   1        core clock, all state on rising edge
//  reset      in   1        asynchronous, active-low (0 = reset)
//  A1         in   5        mfc0 source reg number (rd of M-stage instr)
//  A2         in   5        mtc0 destination reg number (rd of M-stage instr)
//  DIN        in   32       mtc0 write data (forwarded F5out)
//  We         in   1        mtc0 in M stage
//  EXLClr     in   1        eret in M stage
//  valid_M    in   1        M stage holds a real instruction (0 = bubble from a pipeline clear)
//  PC_M       in   32       PC of M-stage instruction
//  PC_E       in   32       PC of E-stage instruction (EPC source when M is a bubble)
//  BD_M       in   1        M-stage instruction sits in a branch delay slot
//  ExcCode_M  in   5        internal exception code of M instr: 0 none, 4 AdEL, 5 AdES, 10 RI, 12 Ov
//  HWInt      in   HWINT_W  level-sensitive device interrupt lines
//  Exception  out  1        take exception this cycle (combinational); drives NPC / pipeline clears
//  EPC        out  32       current EPC register
//  c0out      out  32       combinational read of reg A1 (unknown reg numbers read 0)
// BEHAVIOUR
//  Reset: SR=0, Cause=0, EPC=EPC_RST; Exception=0, c0out=0 (A1 reg values are 0), EPC output=EPC_RST.
//  SR(12):    IM[15:10], EXL[1], IE[0]; other bits read 0, writes ignored.
//  Cause(13): BD[31], IP[15:10], ExcCode[6:2]; read-only to mtc0 (writes ignored).
//  EPC(14):   R/W, bits [1:0] forced 0 on every write.   PRId(15): constant PRID.
//  IntReq  = IE & ~EXL & |(HWInt & IM).   ExcReq = valid_M & (ExcCode_M!=0) & ~EXL.
//  Exception = IntReq | ExcReq (same cycle, no latency). Interrupt has priority over internal exception.
//  On clk edge with Exception=1: EXL<=1; ExcCode<= IntReq ? 0 : ExcCode_M; BD<= valid_M & BD_M;
//   EPC<= src - (BD?4:0), src = valid_M ? PC_M : PC_E, result & ~3. mtc0 and eret that cycle are dropped.
//  IP[15:10] <= HWInt every cycle (sampled, independent of Exception/EXL).
//  mtc0 (We=1, Exception=0): write SR or EPC per A2; new value visible on c0out next cycle; a write that sets
//   IE with a pending masked-in HWInt raises Exception on the following cycle, not the same one.
//  eret (EXLClr=1, Exception=0): EXL<=0 next edge. EXLClr and We both set: both take effect.
//  Read-during-write: c0out returns the OLD value in the write cycle (no bypass).
//  Nested: while EXL=1 all requests masked; HWInt held is taken the cycle after eret retires.
//  Reset asserted mid-exception: state cleared immediately, Exception drops asynchronously with EXL/IE.
// STRUCTURE
//  Shared package/header: CP0 reg numbers (12..15), ExcCode constants (0,4,5,10,12), SR/Cause bit positions.
//  One sub-module: cp0_arbiter (combinational IntReq/ExcReq/priority/ExcCode/EPC-source select).
//  Top holds the four registers, write/read decode and reset logic.
// TESTING
//  reset=0 then 1; read A1=12,13,14,15 -> 0,0,EPC_RST,PRID; Exception=0 with HWInt=6'h3F.
//  mtc0 SR=32'h0000_0401, HWInt[0]=1 -> Exception=1 next cycle; after edge EXL=1, ExcCode=0, EPC=PC_M.
//  valid_M=1, ExcCode_M=12, BD_M=1, PC_M=32'h3010, IE=0 -> Exception=1; EPC=32'h300C, Cause=32'h8000_0030.
//  HWInt+Ov same cycle with IE/IM set -> ExcCode=0 (interrupt wins); mtc0 EPC same cycle ignored.
//  EXL=1, HWInt held -> no Exception; eret retires -> EXL=0, Exception=1 the following cycle.
//  valid_M=0, PC_E=32'h3020, interrupt -> EPC=32'h3020; mtc0 EPC=32'h3007 -> reads 32'h3004.

Source files
------------

// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and SR/Cause field positions.
package cp0_unit_pkg;

  typedef logic [4:0] exc_code_t;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam exc_code_t EXC_NONE = 5'd0;
  localparam exc_code_t EXC_ADEL = 5'd4;
  localparam exc_code_t EXC_ADES = 5'd5;
  localparam exc_code_t EXC_RI   = 5'd10;
  localparam exc_code_t EXC_OV   = 5'd12;

  localparam int SR_IE         = 0;
  localparam int SR_EXL        = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_BD      = 31;

endpackage

// File: rtl/cp0_arbiter.sv
// Combinational exception arbitration: interrupt vs. M-stage exception, new ExcCode/BD and EPC value.
// Zero latency; no backpressure (pure function of current inputs and CP0 state).
module cp0_arbiter
  import cp0_unit_pkg::*;
#(
  parameter int HWINT_W = 6
) (
  input  logic               i_ie,
  input  logic               i_exl,
  input  logic [HWINT_W-1:0] i_im,
  input  logic [HWINT_W-1:0] i_hwint,
  input  logic               i_valid_m,
  input  exc_code_t          i_exc_code_m,
  input  logic               i_bd_m,
  input  logic [31:0]        i_pc_m,
  input  logic [31:0]        i_pc_e,
  output logic               o_exception,
  output exc_code_t          o_exc_code,
  output logic               o_bd,
  output logic [31:0]        o_epc
);

  logic        w_int_req;
  logic        w_exc_req;
  logic [31:0] w_src;
  logic [31:0] w_epc_raw;

  assign w_int_req   = i_ie & ~i_exl & (|(i_hwint & i_im));
  assign w_exc_req   = i_valid_m & (i_exc_code_m != EXC_NONE) & ~i_exl;
  assign o_exception = w_int_req | w_exc_req;
  assign o_exc_code  = w_int_req ? EXC_NONE : i_exc_code_m;
  assign o_bd        = i_valid_m & i_bd_m;

  // A bubble in M has no PC of its own, so restart from the instruction in E.
  assign w_src     = i_valid_m ? i_pc_m : i_pc_e;
  assign w_epc_raw = w_src - (o_bd ? 32'd4 : 32'd0);
  assign o_epc     = w_epc_raw & ~32'h3;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers, mtc0/mfc0/eret handling, exception entry at M-stage retire.
// Exception and c0out are combinational; register updates land on the retiring clock edge.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h2017_0001,
  parameter int          HWINT_W = 6,
  parameter logic [31:0] EPC_RST = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A1,
  input  logic [4:0]         A2,
  input  logic [31:0]        DIN,
  input  logic               We,
  input  logic               EXLClr,
  input  logic               valid_M,
  input  logic [31:0]        PC_M,
  input  logic [31:0]        PC_E,
  input  logic               BD_M,
  input  logic [4:0]         ExcCode_M,
  input  logic [HWINT_W-1:0] HWInt,
  output logic               Exception,
  output logic [31:0]        EPC,
  output logic [31:0]        c0out
);

  logic [HWINT_W-1:0] r_im;
  logic               r_exl;
  logic               r_ie;
  logic               r_bd;
  logic [HWINT_W-1:0] r_ip;
  exc_code_t          r_exc_code;
  logic [31:0]        r_epc;

  logic               w_exception;
  exc_code_t          w_exc_code;
  logic               w_bd;
  logic [31:0]        w_epc;
  logic [31:0]        w_sr;
  logic [31:0]        w_cause;

  cp0_arbiter #(.HWINT_W(HWINT_W)) u_arbiter (
    .i_ie         (r_ie),
    .i_exl        (r_exl),
    .i_im         (r_im),
    .i_hwint      (HWInt),
    .i_valid_m    (valid_M),
    .i_exc_code_m (ExcCode_M),
    .i_bd_m       (BD_M),
    .i_pc_m       (PC_M),
    .i_pc_e       (PC_E),
    .o_exception  (w_exception),
    .o_exc_code   (w_exc_code),
    .o_bd         (w_bd),
    .o_epc        (w_epc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip       <= '0;
      r_exc_code <= EXC_NONE;
      r_epc      <= EPC_RST;
    end else begin
      r_ip <= HWInt;
      if (w_exception) begin
        // Taking the exception squashes any mtc0/eret retiring in the same cycle.
        r_exl      <= 1'b1;
        r_exc_code <= w_exc_code;
        r_bd       <= w_bd;
        r_epc      <= w_epc;
      end else begin
        if (We) begin
          case (A2)
            CP0_SR: begin
              r_im  <= DIN[SR_IM_LSB +: HWINT_W];
              r_exl <= DIN[SR_EXL];
              r_ie  <= DIN[SR_IE];
            end
            CP0_EPC: r_epc <= DIN & ~32'h3;
            default: ;
          endcase
        end
        if (EXLClr) r_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    w_sr                             = '0;
    w_sr[SR_IM_LSB +: HWINT_W]       = r_im;
    w_sr[SR_EXL]                     = r_exl;
    w_sr[SR_IE]                      = r_ie;
    w_cause                          = '0;
    w_cause[CAUSE_BD]                = r_bd;
    w_cause[CAUSE_IP_LSB +: HWINT_W] = r_ip;
    w_cause[CAUSE_EXC_LSB +: 5]      = r_exc_code;
    c0out                            = '0;
    case (A1)
      CP0_SR:    c0out = w_sr;
      CP0_CAUSE: c0out = w_cause;
      CP0_EPC:   c0out = r_epc;
      CP0_PRID:  c0out = PRID;
      default:   c0out = '0;
    endcase
  end

  assign Exception = w_exception;
  assign EPC       = r_epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Scenario-driven bench for cp0_unit: expected register values are queued as stimulus is applied
// and popped when the corresponding read is made.
module tb_cp0_unit;

  localparam logic [31:0] PRID_V = 32'h2017_0001;
  localparam logic [31:0] EPC_RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIN;
  logic        We, EXLClr, valid_M, BD_M;
  logic [31:0] PC_M, PC_E;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        Exception;
  logic [31:0] EPC, c0out;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] want, got;

  always #5 clk = ~clk;

  cp0_unit #(.PRID(PRID_V), .HWINT_W(6), .EPC_RST(EPC_RV)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIN(DIN), .We(We), .EXLClr(EXLClr),
    .valid_M(valid_M), .PC_M(PC_M), .PC_E(PC_E), .BD_M(BD_M), .ExcCode_M(ExcCode_M),
    .HWInt(HWInt), .Exception(Exception), .EPC(EPC), .c0out(c0out)
  );

  task automatic idle();
    We = 1'b0; EXLClr = 1'b0; valid_M = 1'b0; BD_M = 1'b0;
    ExcCode_M = 5'd0; A2 = 5'd0; DIN = 32'd0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    A1 = a;
    #1;
    v = c0out;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle(); A1 = 5'd0; PC_M = '0; PC_E = '0; HWInt = 6'h3F;
    #3;
    n_checks++;
    if (Exception !== 1'b0) begin n_fail++; $display("FAIL exc_in_reset got=%b exp=0", Exception); end
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(EPC_RV); exp_q.push_back(PRID_V);
    want = exp_q.pop_front(); rd(5'd12, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_sr got=%h exp=%h", got, want); end
    n_checks++;
    if (Exception !== 1'b0) begin n_fail++; $display("FAIL rst_exc_hwint got=%b exp=0", Exception); end
    want = exp_q.pop_front(); rd(5'd13, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_cause got=%h exp=%h", got, want); end
    want = exp_q.pop_front(); rd(5'd14, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_epc got=%h exp=%h", got, want); end
    want = exp_q.pop_front(); rd(5'd15, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rst_prid got=%h exp=%h", got, want); end
    HWInt = 6'h00;
  endtask

  task automatic test_interrupt();
    @(negedge clk);
    idle(); We = 1'b1; A2 = 5'd12; DIN = 32'h0000_0401; HWInt = 6'h01;
    exp_q.push_back(32'h0);
    want = exp_q.pop_front(); rd(5'd12, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rdw_sr got=%h exp=%h", got, want); end
    n_checks++;
    if (Exception !== 1'b0) begin n_fail++; $display("FAIL int_same_cycle got=%b exp=0", Exception); end
    @(negedge clk);
    idle(); valid_M = 1'b1; PC_M = 32'h0000_3000;
    exp_q.push_back(32'h0000_0403); exp_q.push_back(32'h0000_0400); exp_q.push_back(32'h0000_3000);
    #1; n_checks++;
    if (Exception !== 1'b1) begin n_fail++; $display("FAIL int_next_cycle got=%b exp=1", Exception); end
    @(negedge clk);
    idle(); HWInt = 6'h00;
    want = exp_q.pop_front(); rd(5'd12, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL int_sr got=%h exp=%h", got, want); end
    want = exp_q.pop_front(); rd(5'd13, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL int_cause got=%h exp=%h", got, want); end
    want = exp_q.pop_front(); rd(5'd14, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL int_epc got=%h exp=%h", got, want); end
    // eret together with mtc0 SR=0: both must land
    EXLClr = 1'b1; We = 1'b1; A2 = 5'd12; DIN = 32'h0;
    exp_q.push_back(32'h0);
    @(negedge clk);
    idle();
    want = exp_q.pop_front(); rd(5'd12, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL eret_mtc0_sr got=%h exp=%h", got, want); end
  endtask

  task automatic test_exc_bd();
    @(negedge clk);
    idle(); valid_M = 1'b1; ExcCode_M = 5'd12; BD_M = 1'b1; PC_M = 32'h0000_3010;
    exp_q.push_back(32'h0000_300C); exp_q.push_back(32'h8000_0030); exp_q.push_back(32'h0000_0002);
    exp_q.push_back(32'h0);
    #1; n_checks++;
    if (Exception !== 1'b1) begin n_fail++; $display("FAIL ov_exc got=%b exp=1", Exception); end
    @(negedge clk);
    idle();
    want = exp_q.pop_front(); rd(5'd14, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL bd_epc got=%h exp=%h", got, want); end
    want = exp_q.pop_front(); rd(5'd13, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL bd_cause got=%h exp=%h", got, want); end
    want = exp_q.pop_front(); rd(5'd12, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL bd_sr got=%h exp=%h", got, want); end
    want = exp_q.pop_front(); rd(5'd5, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL unknown_reg got=%h exp=%h", got, want); end
    EXLClr = 1'b1;
    @(negedge clk);
    idle();
  endtask

  task automatic test_priority();
    idle(); We = 1'b1; A2 = 5'd12; DIN = 32'h0000_0401;
    @(negedge clk);
    idle(); HWInt = 6'h01; valid_M = 1'b1; ExcCode_M = 5'd12; PC_M = 32'h0000_3040;
    We = 1'b1; A2 = 5'd14; DIN = 32'h0000_1234;
    exp_q.push_back(32'h0000_0400); exp_q.push_back(32'h0000_3040); exp_q.push_back(32'h0000_0403);
    #1; n_checks++;
    if (Exception !== 1'b1) begin n_fail++; $display("FAIL prio_exc got=%b exp=1", Exception); end
    @(negedge clk);
    idle();
    want = exp_q.pop_front(); rd(5'd13, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL prio_cause got=%h exp=%h", got, want); end
    want = exp_q.pop_front(); rd(5'd14, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL prio_epc got=%h exp=%h", got, want); end
    want = exp_q.pop_front(); rd(5'd12, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL prio_sr got=%h exp=%h", got, want); end
  endtask

  task automatic test_nested();
    // EXL=1, IE=1, HWInt[0] still held from the previous scenario
    valid_M = 1'b1; ExcCode_M = 5'd4; PC_M = 32'h0000_3050;
    #1; n_checks++;
    if (Exception !== 1'b0) begin n_fail++; $display("FAIL nested_mask got=%b exp=0", Exception); end
    @(negedge clk);
    idle(); EXLClr = 1'b1;
    #1; n_checks++;
    if (Exception !== 1'b0) begin n_fail++; $display("FAIL eret_cycle got=%b exp=0", Exception); end
    @(negedge clk);
    idle();
    exp_q.push_back(32'h0000_0401);
    want = exp_q.pop_front(); rd(5'd12, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL after_eret_sr got=%h exp=%h", got, want); end
    n_checks++;
    if (Exception !== 1'b1) begin n_fail++; $display("FAIL after_eret_exc got=%b exp=1", Exception); end
    valid_M = 1'b0; PC_E = 32'h0000_3020; PC_M = 32'hDEAD_0000;
    exp_q.push_back(32'h0000_3020); exp_q.push_back(32'h0000_3020); exp_q.push_back(32'h0000_3004);
    @(negedge clk);
    idle(); HWInt = 6'h00;
    want = exp_q.pop_front(); rd(5'd14, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL bubble_epc got=%h exp=%h", got, want); end
    We = 1'b1; A2 = 5'd14; DIN = 32'h0000_3007; EXLClr = 1'b1;
    want = exp_q.pop_front(); rd(5'd14, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL rdw_epc got=%h exp=%h", got, want); end
    @(negedge clk);
    idle();
    want = exp_q.pop_front(); rd(5'd14, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL epc_align got=%h exp=%h", got, want); end
    n_checks++;
    if (Exception !== 1'b0) begin n_fail++; $display("FAIL quiet_after_eret got=%b exp=0", Exception); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle(); HWInt = 6'h01;
    #1; n_checks++;
    if (Exception !== 1'b1) begin n_fail++; $display("FAIL pre_reset_exc got=%b exp=1", Exception); end
    reset = 1'b0;
    #1; n_checks++;
    if (Exception !== 1'b0) begin n_fail++; $display("FAIL async_drop got=%b exp=0", Exception); end
    n_checks++;
    if (EPC !== EPC_RV) begin n_fail++; $display("FAIL async_epc_port got=%h exp=%h", EPC, EPC_RV); end
    exp_q.push_back(32'h0);
    want = exp_q.pop_front(); rd(5'd12, got); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL async_sr got=%h exp=%h", got, want); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (Exception !== 1'b0) begin n_fail++; $display("FAIL post_reset_exc got=%b exp=0", Exception); end
    HWInt = 6'h00;
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exc_bd();
    test_priority();
    test_nested();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
